// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: CPU/DMA arbitration into a TX FIFO and uart_tx sequencing.
// Optional inter-frame gap state enabled by defining UART_TX_SCHED_GAP_EN.
module uart_tx_sched #(
    parameter int DEPTH         = 16,
    parameter int DW            = 8,
    parameter int TXDRDY_THRESH = 8
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic                       cpu_wr_valid,
    input  logic [DW-1:0]              cpu_wr_data,
    output logic                       cpu_wr_ready,
    input  logic                       dma_wr_valid,
    input  logic [DW-1:0]              dma_wr_data,
    output logic                       dma_wr_ready,
    input  logic                       dma_en,
    input  logic                       fifo_clr,
    output logic                       tx_start,
    output logic [DW-1:0]              tx_data,
    input  logic                       tx_busy,
    input  logic                       baud_tick,
`ifdef UART_TX_SCHED_GAP_EN
    input  logic [3:0]                 gap_ticks,
`endif
    output logic                       tx_fifo_empty,
    output logic                       tx_idle,
    output logic [$clog2(DEPTH):0]     tx_fifo_level,
    output logic                       TXDRDYn
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

`ifdef UART_TX_SCHED_GAP_EN
    typedef enum logic [1:0] {IDLE, WAIT_ACK, SEND, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT_ACK, SEND} state_t;
`endif

    state_t          state, state_n;
    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level;
    logic            last_dma;
    logic [3:0]      tick_cnt;
    logic            full, empty;
    logic            dma_req, grant_cpu, grant_dma;
    logic            cpu_push, dma_push, push, pop;
    logic            cnt_clr, cnt_inc;
    logic [DW-1:0]   push_data;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // Round-robin: a path loses only when the other is requesting and it is the other's turn.
    assign dma_req   = dma_wr_valid & dma_en;
    assign grant_cpu = !(dma_req & !last_dma);
    assign grant_dma = !(cpu_wr_valid & last_dma);

    assign cpu_wr_ready = !full & !fifo_clr & grant_cpu;
    assign dma_wr_ready = dma_en & !full & !fifo_clr & grant_dma;

    assign cpu_push  = cpu_wr_valid & cpu_wr_ready;
    assign dma_push  = dma_wr_valid & dma_wr_ready;
    assign push      = cpu_push | dma_push;
    assign push_data = cpu_push ? cpu_wr_data : dma_wr_data;

    assign tx_fifo_empty = empty;
    assign tx_fifo_level = level;
    assign tx_idle       = empty & (state == IDLE) & !tx_busy;

    // FIFO storage; contents need no reset since level gates every read.
    always_ff @(posedge PCLK) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // FIFO pointers and occupancy; a flush overrides any push or pop.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (fifo_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push & !pop)      level <= level + 1'b1;
            else if (pop & !push) level <= level - 1'b1;
        end
    end

    // Remember which path won the last accepted push for round-robin.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)        last_dma <= 1'b1;
        else if (cpu_push) last_dma <= 1'b0;
        else if (dma_push) last_dma <= 1'b1;
    end

    // Frame launch registers and the registered DMA request.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tx_start <= 1'b0;
            tx_data  <= '0;
            TXDRDYn  <= 1'b1;
        end else begin
            tx_start <= pop;
            if (pop) tx_data <= mem[rd_ptr];
            TXDRDYn  <= !(dma_en & (level <= LW'(TXDRDY_THRESH)));
        end
    end

    // State register and baud tick counter shared by ack timeout and gap.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            tick_cnt <= '0;
        end else begin
            state <= state_n;
            if (cnt_clr)      tick_cnt <= '0;
            else if (cnt_inc) tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Next-state logic: pop in IDLE, await busy, await end of frame.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !tx_busy && !fifo_clr) begin
                    pop     = 1'b1;
                    cnt_clr = 1'b1;
                    state_n = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_n = SEND;
                end else if (baud_tick) begin
                    if (tick_cnt == 4'd1) state_n = IDLE;
                    else                  cnt_inc = 1'b1;
                end
            end
            SEND: begin
                if (!tx_busy) begin
`ifdef UART_TX_SCHED_GAP_EN
                    state_n = GAP;
                    cnt_clr = 1'b1;
`else
                    state_n = IDLE;
`endif
                end
            end
`ifdef UART_TX_SCHED_GAP_EN
            GAP: begin
                if (tick_cnt == gap_ticks) state_n = IDLE;
                else if (baud_tick)        cnt_inc = 1'b1;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched with a behavioural uart_tx model.
// Transmitted bytes are checked against a scoreboard queue in order.
module tb_uart_tx_sched;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       cpu_wr_valid, dma_wr_valid, dma_en, fifo_clr;
    logic [7:0] cpu_wr_data, dma_wr_data;
    logic       cpu_wr_ready, dma_wr_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       baud_tick;
    logic       tx_fifo_empty, tx_idle, TXDRDYn;
    logic [4:0] tx_fifo_level;
`ifdef UART_TX_SCHED_GAP_EN
    logic [3:0] gap_ticks;
`endif

    int ntests = 0;
    int nfail  = 0;

    logic       mbusy, hold, ack_en;
    int         bcnt, bits, frames;
    logic [7:0] exp_q [$];

    assign tx_busy = mbusy | hold;

    uart_tx_sched dut (
        .PCLK          (PCLK),
        .PRESET        (PRESET),
        .cpu_wr_valid  (cpu_wr_valid),
        .cpu_wr_data   (cpu_wr_data),
        .cpu_wr_ready  (cpu_wr_ready),
        .dma_wr_valid  (dma_wr_valid),
        .dma_wr_data   (dma_wr_data),
        .dma_wr_ready  (dma_wr_ready),
        .dma_en        (dma_en),
        .fifo_clr      (fifo_clr),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_busy       (tx_busy),
        .baud_tick     (baud_tick),
`ifdef UART_TX_SCHED_GAP_EN
        .gap_ticks     (gap_ticks),
`endif
        .tx_fifo_empty (tx_fifo_empty),
        .tx_idle       (tx_idle),
        .tx_fifo_level (tx_fifo_level),
        .TXDRDYn       (TXDRDYn)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // uart_tx model: baud tick every 4 cycles, busy for 10 ticks per frame.
    always @(negedge PCLK) begin
        logic [7:0] e;
        baud_tick = (bcnt == 3);
        bcnt = (bcnt + 1) % 4;
        if (PRESET) begin
            mbusy = 1'b0;
        end else if (tx_start) begin
            frames++;
            if (tx_busy) chk("start_while_busy", 1, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_start", {24'h0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("tx_data_order", {24'h0, tx_data}, {24'h0, e});
            end
            if (ack_en) begin
                mbusy = 1'b1;
                bits  = 0;
            end
        end else if (mbusy && baud_tick) begin
            bits++;
            if (bits == 10) mbusy = 1'b0;
        end
    end

    task automatic cyc();
        @(negedge PCLK);
        #1;
    endtask

    task automatic cpu_push1(input logic [7:0] d);
        cpu_wr_valid = 1'b1;
        cpu_wr_data  = d;
        #1;
        chk("cpu_push_ready", {31'h0, cpu_wr_ready}, 1);
        cyc();
        cpu_wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int lim);
        int k = 0;
        while (!(tx_idle && exp_q.size() == 0) && k < lim) begin
            cyc();
            k++;
        end
        chk(nm, {31'h0, tx_idle}, 1);
    endtask

    typedef struct {
        logic       cv;
        logic [7:0] cd;
        logic       dv;
        logic [7:0] dd;
        logic       den;
        logic       ec;
        logic       ed;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int f0, k;
        logic ca, da;
        tbl[0]  = '{1'b1, 8'h10, 1'b1, 8'h20, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 8'h11, 1'b1, 8'h20, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 8'h11, 1'b1, 8'h21, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 8'h12, 1'b1, 8'h21, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 8'h12, 1'b1, 8'h23, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 8'h13, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 8'h14, 1'b1, 8'h23, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 8'h14, 1'b1, 8'h24, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 8'h24, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 8'h15, 1'b1, 8'h24, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

        PRESET = 1'b1;
        cpu_wr_valid = 0; cpu_wr_data = 0;
        dma_wr_valid = 0; dma_wr_data = 0;
        dma_en = 0; fifo_clr = 0;
        hold = 0; ack_en = 1; mbusy = 0;
        bcnt = 0; bits = 0; frames = 0;
`ifdef UART_TX_SCHED_GAP_EN
        gap_ticks = 4'd3;
`endif
        repeat (3) cyc();
        PRESET = 1'b0;
        #1;
        chk("rst_level", {27'h0, tx_fifo_level}, 0);
        chk("rst_empty", {31'h0, tx_fifo_empty}, 1);
        chk("rst_idle", {31'h0, tx_idle}, 1);
        chk("rst_txdrdyn", {31'h0, TXDRDYn}, 1);
        chk("rst_start", {31'h0, tx_start}, 0);
        chk("rst_data", {24'h0, tx_data}, 0);

        // single byte, two-cycle latency
        exp_q.push_back(8'hA5);
        cpu_push1(8'hA5);
        chk("lat_cycle1_start", {31'h0, tx_start}, 0);
        cyc();
        chk("lat_cycle2_start", {31'h0, tx_start}, 1);
        chk("lat_cycle2_data", {24'h0, tx_data}, 8'hA5);
        wait_idle("single_idle", 300);
        chk("single_empty", {31'h0, tx_fifo_empty}, 1);

        // fill to full with busy held, then drain in order
        hold = 1'b1;
        cyc();
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i));
            cpu_push1(8'(i));
        end
        cpu_wr_valid = 1'b1;
        cpu_wr_data  = 8'h10;
        #1;
        chk("full_level", {27'h0, tx_fifo_level}, 16);
        chk("full_ready", {31'h0, cpu_wr_ready}, 0);
        cyc();
        chk("full_stall_level", {27'h0, tx_fifo_level}, 16);
        cpu_wr_valid = 1'b0;
        f0 = frames;
        hold = 1'b0;
        wait_idle("full_drain_idle", 3000);
        chk("full_drain_frames", frames - f0, 16);

        // arbitration table, fresh reset so CPU wins first contention
        PRESET = 1'b1;
        cyc();
        PRESET = 1'b0;
        hold = 1'b1;
        cyc();
        for (int i = 0; i < 12; i++) begin
            cpu_wr_valid = tbl[i].cv;
            cpu_wr_data  = tbl[i].cd;
            dma_wr_valid = tbl[i].dv;
            dma_wr_data  = tbl[i].dd;
            dma_en       = tbl[i].den;
            #1;
            ca = cpu_wr_valid & cpu_wr_ready;
            da = dma_wr_valid & dma_wr_ready;
            chk($sformatf("arb_cpu_acc_%0d", i), {31'h0, ca}, {31'h0, tbl[i].ec});
            chk($sformatf("arb_dma_acc_%0d", i), {31'h0, da}, {31'h0, tbl[i].ed});
            if (tbl[i].ec) exp_q.push_back(tbl[i].cd);
            if (tbl[i].ed) exp_q.push_back(tbl[i].dd);
            cyc();
        end
        cpu_wr_valid = 0;
        dma_wr_valid = 0;
        chk("arb_level", {27'h0, tx_fifo_level}, 10);

        // TXDRDYn threshold crossing and dma_en gating
        dma_en = 1'b1;
        cyc();
        chk("drdy_above", {31'h0, TXDRDYn}, 1);
        hold = 1'b0;
        k = 0;
        while (tx_fifo_level != 8 && k < 500) begin
            cyc();
            k++;
        end
        chk("drdy_reach8", {27'h0, tx_fifo_level}, 8);
        chk("drdy_at8_same", {31'h0, TXDRDYn}, 1);
        cyc();
        chk("drdy_at8_next", {31'h0, TXDRDYn}, 0);
        dma_en = 1'b0;
        dma_wr_valid = 1'b1;
        #1;
        chk("dma_dis_ready", {31'h0, dma_wr_ready}, 0);
        cyc();
        chk("dma_dis_drdy", {31'h0, TXDRDYn}, 1);
        dma_wr_valid = 1'b0;
        wait_idle("arb_drain_idle", 3000);

        // no ack from uart_tx: frame dropped after timeout, next one works
        ack_en = 1'b0;
        f0 = frames;
        exp_q.push_back(8'h40);
        cpu_push1(8'h40);
        wait_idle("noack_idle", 200);
        chk("noack_frames", frames - f0, 1);
        ack_en = 1'b1;
        exp_q.push_back(8'h41);
        cpu_push1(8'h41);
        wait_idle("ack_again_idle", 300);
        chk("ack_again_frames", frames - f0, 2);

        // flush with a frame in flight and five queued
        hold = 1'b1;
        cyc();
        exp_q.push_back(8'h30);
        for (int i = 0; i < 6; i++) cpu_push1(8'(8'h30 + i));
        hold = 1'b0;
        k = 0;
        while (!(tx_fifo_level == 5 && mbusy) && k < 100) begin
            cyc();
            k++;
        end
        chk("clr_pre_level", {27'h0, tx_fifo_level}, 5);
        cpu_wr_valid = 1'b1;
        cpu_wr_data  = 8'hEE;
        fifo_clr     = 1'b1;
        #1;
        chk("clr_refuse", {31'h0, cpu_wr_ready}, 0);
        cyc();
        fifo_clr     = 1'b0;
        cpu_wr_valid = 1'b0;
        chk("clr_level", {27'h0, tx_fifo_level}, 0);
        chk("clr_empty", {31'h0, tx_fifo_empty}, 1);
        chk("clr_data_held", {24'h0, tx_data}, 8'h30);
        f0 = frames;
        wait_idle("clr_idle", 300);
        repeat (20) cyc();
        chk("clr_no_start", frames - f0, 0);

`ifdef UART_TX_SCHED_GAP_EN
        // inter-frame gap of three baud ticks
        hold = 1'b1;
        cyc();
        exp_q.push_back(8'h51);
        exp_q.push_back(8'h52);
        cpu_push1(8'h51);
        cpu_push1(8'h52);
        f0 = frames;
        hold = 1'b0;
        k = 0;
        while (!(frames == f0 + 1 && mbusy) && k < 100) begin
            cyc();
            k++;
        end
        while (mbusy && k < 300) begin
            cyc();
            k++;
        end
        cyc();
        bits = 0;
        while (!tx_start && k < 400) begin
            if (baud_tick) bits++;
            cyc();
            k++;
        end
        chk("gap_ticks", bits, 3);
        wait_idle("gap_idle", 300);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
